axi2wbm_bridge: RTL and testbench

//  AXI4 slave that accepts bursts from an AXI master and replays them as pipelined Wishbone master cycles.
//  It is the opposite direction to the WB-to-AXI translator feeding the SDRAM controller.
//  It lets AXI-native cores (DMA, debug) reach the Wishbone peripheral bus.
//  One burst in flight at a time; one WB beat per AXI beat; equal data widths, no width conversion.

---
 rtl/axi2wbm_bridge.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_axi2wbm_bridge.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2wbm_bridge.sv
// axi2wbm_bridge: AXI4 slave that replays each accepted burst as a sequence of
// pipelined Wishbone master cycles, one WB beat per AXI beat, one burst at a time.
// Optional feature macro: AXI2WBM_WRAP_EN
//   defined   - WRAP bursts are translated (address wraps in a (len+1)-word window)
//   undefined - WRAP bursts issue no WB cycle; writes drain W and return SLVERR,
//               reads return len+1 beats of zero data with SLVERR
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for AW or AR; ties alternate, read wins first
// WADDR  | write beat: waiting for W data (cyc held between beats)
// WBEAT  | write strobe presented, waiting for !stall
// WACK   | write beat issued, waiting for ack/err
// BRESP  | write burst done, presenting B response
// RBEAT  | read strobe presented, waiting for !stall
// RACK   | read beat issued, waiting for ack/err
// RDATA  | presenting captured read beat on R until accepted
module axi2wbm_bridge #(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int DW               = 32,
    parameter int AW               = C_AXI_ADDR_WIDTH - $clog2(DW/8)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [C_AXI_ID_WIDTH-1:0]   i_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_awaddr,
    input  logic [7:0]                  i_axi_awlen,
    input  logic [1:0]                  i_axi_awburst,
    input  logic                        i_axi_awvalid,
    output logic                        o_axi_awready,
    input  logic [DW-1:0]               i_axi_wdata,
    input  logic [DW/8-1:0]             i_axi_wstrb,
    input  logic                        i_axi_wlast,
    input  logic                        i_axi_wvalid,
    output logic                        o_axi_wready,
    output logic [C_AXI_ID_WIDTH-1:0]   o_axi_bid,
    output logic [1:0]                  o_axi_bresp,
    output logic                        o_axi_bvalid,
    input  logic                        i_axi_bready,
    input  logic [C_AXI_ID_WIDTH-1:0]   i_axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_araddr,
    input  logic [7:0]                  i_axi_arlen,
    input  logic [1:0]                  i_axi_arburst,
    input  logic                        i_axi_arvalid,
    output logic                        o_axi_arready,
    output logic [C_AXI_ID_WIDTH-1:0]   o_axi_rid,
    output logic [DW-1:0]               o_axi_rdata,
    output logic [1:0]                  o_axi_rresp,
    output logic                        o_axi_rlast,
    output logic                        o_axi_rvalid,
    input  logic                        i_axi_rready,
    output logic                        o_wb_cyc,
    output logic                        o_wb_stb,
    output logic                        o_wb_we,
    output logic [AW-1:0]               o_wb_addr,
    output logic [DW-1:0]               o_wb_data,
    output logic [DW/8-1:0]             o_wb_sel,
    input  logic                        i_wb_stall,
    input  logic                        i_wb_ack,
    input  logic                        i_wb_err,
    input  logic [DW-1:0]               i_wb_data
);

    localparam int LSB = $clog2(DW/8);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WBEAT, S_WACK, S_BRESP, S_RBEAT, S_RACK, S_RDATA
    } state_t;

    state_t                     state_q, state_d;
    logic [C_AXI_ID_WIDTH-1:0]  id_q, id_d;
    logic [AW-1:0]              addr_q, addr_d, addr_nxt;
    logic [1:0]                 burst_q, burst_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic                       bad_q, bad_d;
    logic                       prefer_wr_q, prefer_wr_d;
    logic                       cyc_q, cyc_d;
    logic                       stb_q, stb_d;
    logic                       we_q, we_d;
    logic [DW-1:0]              wdata_q, wdata_d;
    logic [DW/8-1:0]            sel_q, sel_d;
    logic [DW-1:0]              rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic                       grant_rd, grant_wr;
    logic                       aw_bad, ar_bad;

    // Sub-word address bits and wlast carry no information for this bridge.
    logic unused_ok;
    assign unused_ok = ^{i_axi_wlast, i_axi_awaddr[LSB-1:0], i_axi_araddr[LSB-1:0]};

`ifdef AXI2WBM_WRAP_EN
    logic [7:0] len_q, len_d;
    logic [AW-1:0] wrap_mask;

    assign aw_bad    = 1'b0;
    assign ar_bad    = 1'b0;
    assign wrap_mask = AW'(len_q);
`else
    assign aw_bad = (i_axi_awburst == 2'b10);
    assign ar_bad = (i_axi_arburst == 2'b10);
`endif

    // Word address of the following beat: FIXED holds, WRAP folds into its window, else increments.
    always_comb begin
        addr_nxt = addr_q + AW'(1);
        if (burst_q == 2'b00) begin
            addr_nxt = addr_q;
        end
`ifdef AXI2WBM_WRAP_EN
        else if (burst_q == 2'b10) begin
            addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + AW'(1)) & wrap_mask);
        end
`endif
    end

    // Next-state and handshake decode; every register holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        bad_d       = bad_q;
        prefer_wr_d = prefer_wr_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
`ifdef AXI2WBM_WRAP_EN
        len_d       = len_q;
`endif
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        o_axi_awready = 1'b0;
        o_axi_arready = 1'b0;
        o_axi_wready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant_rd = i_axi_arvalid && (!i_axi_awvalid || !prefer_wr_q);
                grant_wr = i_axi_awvalid && !grant_rd;
                o_axi_arready = grant_rd;
                o_axi_awready = grant_wr;
                if (grant_rd) begin
                    id_d        = i_axi_arid;
                    addr_d      = i_axi_araddr[C_AXI_ADDR_WIDTH-1:LSB];
                    burst_d     = i_axi_arburst;
                    cnt_d       = i_axi_arlen;
                    bad_d       = ar_bad;
                    prefer_wr_d = 1'b1;
`ifdef AXI2WBM_WRAP_EN
                    len_d       = i_axi_arlen;
`endif
                    if (ar_bad) begin
                        rdata_d = '0;
                        rresp_d = 2'b10;
                        state_d = S_RDATA;
                    end else begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        state_d = S_RBEAT;
                    end
                end else if (grant_wr) begin
                    id_d        = i_axi_awid;
                    addr_d      = i_axi_awaddr[C_AXI_ADDR_WIDTH-1:LSB];
                    burst_d     = i_axi_awburst;
                    cnt_d       = i_axi_awlen;
                    bad_d       = aw_bad;
                    err_d       = 1'b0;
                    prefer_wr_d = 1'b0;
`ifdef AXI2WBM_WRAP_EN
                    len_d       = i_axi_awlen;
`endif
                    state_d     = S_WADDR;
                end
            end
            S_WADDR: begin
                o_axi_wready = 1'b1;
                if (i_axi_wvalid) begin
                    if (bad_q) begin
                        // unsupported burst: swallow the beat, no WB traffic
                        err_d = 1'b1;
                        if (cnt_q == 8'd0) state_d = S_BRESP;
                        else               cnt_d   = cnt_q - 8'd1;
                    end else begin
                        wdata_d = i_axi_wdata;
                        sel_d   = i_axi_wstrb;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        state_d = S_WBEAT;
                    end
                end
            end
            S_WBEAT: begin
                if (!i_wb_stall) begin
                    stb_d   = 1'b0;
                    state_d = S_WACK;
                end
            end
            S_WACK: begin
                if (i_wb_ack || i_wb_err) begin
                    if (i_wb_err) err_d = 1'b1;
                    if (cnt_q == 8'd0) begin
                        cyc_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = S_BRESP;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_nxt;
                        state_d = S_WADDR;
                    end
                end
            end
            S_BRESP: begin
                if (i_axi_bready) state_d = S_IDLE;
            end
            S_RBEAT: begin
                if (!i_wb_stall) begin
                    stb_d   = 1'b0;
                    state_d = S_RACK;
                end
            end
            S_RACK: begin
                if (i_wb_ack || i_wb_err) begin
                    rdata_d = i_wb_data;
                    rresp_d = i_wb_err ? 2'b10 : 2'b00;
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (i_axi_rready) begin
                    if (cnt_q == 8'd0) begin
                        cyc_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = addr_nxt;
                        if (!bad_q) begin
                            stb_d   = 1'b1;
                            state_d = S_RBEAT;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops the WB cycle at once and discards the burst.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            bad_q       <= 1'b0;
            prefer_wr_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            sel_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
`ifdef AXI2WBM_WRAP_EN
            len_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            bad_q       <= bad_d;
            prefer_wr_q <= prefer_wr_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
`ifdef AXI2WBM_WRAP_EN
            len_q       <= len_d;
`endif
        end
    end

    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = we_q;
    assign o_wb_addr    = addr_q;
    assign o_wb_data    = wdata_q;
    assign o_wb_sel     = sel_q;

    assign o_axi_bvalid = (state_q == S_BRESP);
    assign o_axi_bid    = id_q;
    assign o_axi_bresp  = {err_q, 1'b0};

    assign o_axi_rvalid = (state_q == S_RDATA);
    assign o_axi_rid    = id_q;
    assign o_axi_rdata  = rdata_q;
    assign o_axi_rresp  = rresp_q;
    assign o_axi_rlast  = (state_q == S_RDATA) && (cnt_q == 8'd0);

endmodule

// File: tb/tb_axi2wbm_bridge.sv
// Scoreboard bench for axi2wbm_bridge: stimulus pushes expected WB beats, R beats
// and B responses from a burst-level model; one monitor pops and compares.
module tb_axi2wbm_bridge;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [0:0]  i_axi_awid, i_axi_arid, o_axi_bid, o_axi_rid;
    logic [27:0] i_axi_awaddr, i_axi_araddr;
    logic [7:0]  i_axi_awlen, i_axi_arlen;
    logic [1:0]  i_axi_awburst, i_axi_arburst, o_axi_bresp, o_axi_rresp;
    logic        i_axi_awvalid, o_axi_awready, i_axi_wlast, i_axi_wvalid, o_axi_wready;
    logic [31:0] i_axi_wdata, o_axi_rdata, o_wb_data, i_wb_data;
    logic [3:0]  i_axi_wstrb, o_wb_sel;
    logic        o_axi_bvalid, i_axi_bready, i_axi_arvalid, o_axi_arready;
    logic        o_axi_rlast, o_axi_rvalid, i_axi_rready;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, i_wb_stall, i_wb_ack, i_wb_err;
    logic [25:0] o_wb_addr;

    always #5 i_clk = ~i_clk;

    axi2wbm_bridge dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_axi_awid(i_axi_awid), .i_axi_awaddr(i_axi_awaddr), .i_axi_awlen(i_axi_awlen),
        .i_axi_awburst(i_axi_awburst), .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready),
        .i_axi_wdata(i_axi_wdata), .i_axi_wstrb(i_axi_wstrb), .i_axi_wlast(i_axi_wlast),
        .i_axi_wvalid(i_axi_wvalid), .o_axi_wready(o_axi_wready),
        .o_axi_bid(o_axi_bid), .o_axi_bresp(o_axi_bresp), .o_axi_bvalid(o_axi_bvalid),
        .i_axi_bready(i_axi_bready),
        .i_axi_arid(i_axi_arid), .i_axi_araddr(i_axi_araddr), .i_axi_arlen(i_axi_arlen),
        .i_axi_arburst(i_axi_arburst), .i_axi_arvalid(i_axi_arvalid), .o_axi_arready(o_axi_arready),
        .o_axi_rid(o_axi_rid), .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp),
        .o_axi_rlast(o_axi_rlast), .o_axi_rvalid(o_axi_rvalid), .i_axi_rready(i_axi_rready),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    typedef struct { logic we; logic [25:0] adr; logic [31:0] dat; logic [3:0] sel; } wb_t;
    typedef struct { logic [31:0] dat; logic [1:0] resp; logic last; logic id; } r_t;
    typedef struct { logic [1:0] resp; logic id; } b_t;

    wb_t exp_wb[$];
    r_t  exp_r[$];
    b_t  exp_b[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  last_rd  = 1'b0;   // model of the tie-break: read wins when the last grant was a write
    bit  err_mode = 1'b0;
    bit  force_stall = 1'b0;
    int  r_hold = 0;
    logic [31:0] wd[16];
    logic [3:0]  ws[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // ---------------- reference model ----------------
    function automatic bit slave_err(input logic [25:0] adr);
        return err_mode && (adr[1:0] == 2'b01);
    endfunction

    function automatic logic [31:0] slave_data(input logic [25:0] adr);
        return {adr[15:0] ^ 16'hA5A5, adr[15:0]};
    endfunction

    function automatic bit unsupported(input logic [1:0] b);
`ifdef AXI2WBM_WRAP_EN
        return (b == 2'b11) && 1'b0;
`else
        return b == 2'b10;
`endif
    endfunction

    // word address of beat i, from the burst rules in plain arithmetic
    function automatic logic [25:0] beat_adr(input logic [27:0] a, input logic [7:0] len,
                                             input logic [1:0] b, input int i);
        int unsigned w, n, base, off;
        w = 32'(a[27:2]);
        n = 32'(len) + 1;
        if (b == 2'b00) return 26'(w);
        if (b == 2'b10) begin
            base = w - (w % n);
            off  = ((w % n) + 32'(i)) % n;
            return 26'(base + off);
        end
        return 26'(w + 32'(i));   // modulo 2^26 by truncation
    endfunction

    function automatic void model_write(input logic id, input logic [27:0] a,
                                        input logic [7:0] len, input logic [1:0] b);
        bit e = 1'b0;
        logic [25:0] adr;
        last_rd = 1'b0;
        if (unsupported(b)) begin
            exp_b.push_back('{resp: 2'b10, id: id});
            return;
        end
        for (int i = 0; i <= int'(len); i++) begin
            adr = beat_adr(a, len, b, i);
            exp_wb.push_back('{we: 1'b1, adr: adr, dat: wd[i], sel: ws[i]});
            if (slave_err(adr)) e = 1'b1;
        end
        exp_b.push_back('{resp: (e ? 2'b10 : 2'b00), id: id});
    endfunction

    function automatic void model_read(input logic id, input logic [27:0] a,
                                       input logic [7:0] len, input logic [1:0] b);
        logic [25:0] adr;
        last_rd = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            if (unsupported(b)) begin
                exp_r.push_back('{dat: 32'h0, resp: 2'b10, last: (i == int'(len)), id: id});
            end else begin
                adr = beat_adr(a, len, b, i);
                exp_wb.push_back('{we: 1'b0, adr: adr, dat: 32'h0, sel: 4'h0});
                exp_r.push_back('{dat: slave_data(adr), resp: (slave_err(adr) ? 2'b10 : 2'b00),
                                  last: (i == int'(len)), id: id});
            end
        end
    endfunction

    // ---------------- WB slave ----------------
    initial begin
        logic [25:0] adr;
        bit e;
        int d;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                adr = o_wb_addr;
                @(posedge i_clk); #1;
                i_wb_stall = force_stall || ($urandom % 4 == 0);
                d = $urandom_range(0, 2);
                repeat (d) begin @(posedge i_clk); #1; end
                e = slave_err(adr);
                i_wb_ack = !e; i_wb_err = e; i_wb_data = slave_data(adr);
                @(posedge i_clk); #1;
                i_wb_ack = 1'b0; i_wb_err = 1'b0;
            end else begin
                @(posedge i_clk); #1;
                i_wb_stall = force_stall || ($urandom % 4 == 0);
            end
        end
    end

    // ---------------- R/B ready drivers ----------------
    initial begin
        i_axi_rready = 1'b0; i_axi_bready = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            if (r_hold > 0) begin
                i_axi_rready = 1'b0;
                if (o_axi_rvalid) r_hold--;
            end else begin
                i_axi_rready = ($urandom % 4) != 0;
            end
            i_axi_bready = ($urandom % 3) != 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        wb_t ew; r_t er; b_t eb;
        bit r_pend = 1'b0;
        logic [31:0] h_dat; logic [1:0] h_resp; logic h_last;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                r_pend = 1'b0;
            end else begin
                if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                    if (exp_wb.size() == 0) fail("wb_unexpected_beat");
                    else begin
                        ew = exp_wb.pop_front();
                        chk("wb_we", 64'(o_wb_we), 64'(ew.we));
                        chk("wb_adr", 64'(o_wb_addr), 64'(ew.adr));
                        if (ew.we) begin
                            chk("wb_dat", 64'(o_wb_data), 64'(ew.dat));
                            chk("wb_sel", 64'(o_wb_sel), 64'(ew.sel));
                        end
                    end
                end
                if (o_axi_rvalid) chk("no_stb_while_rvalid", 64'(o_wb_stb), 64'(0));
                if (r_pend) begin
                    chk("r_hold_valid", 64'(o_axi_rvalid), 64'(1));
                    chk("r_hold_data", 64'(o_axi_rdata), 64'(h_dat));
                    chk("r_hold_resp", 64'(o_axi_rresp), 64'(h_resp));
                    chk("r_hold_last", 64'(o_axi_rlast), 64'(h_last));
                end
                r_pend = o_axi_rvalid && !i_axi_rready;
                h_dat = o_axi_rdata; h_resp = o_axi_rresp; h_last = o_axi_rlast;
                if (o_axi_rvalid && i_axi_rready) begin
                    if (exp_r.size() == 0) fail("r_unexpected_beat");
                    else begin
                        er = exp_r.pop_front();
                        chk("r_data", 64'(o_axi_rdata), 64'(er.dat));
                        chk("r_resp", 64'(o_axi_rresp), 64'(er.resp));
                        chk("r_last", 64'(o_axi_rlast), 64'(er.last));
                        chk("r_id", 64'(o_axi_rid), 64'(er.id));
                    end
                end
                if (o_axi_bvalid && i_axi_bready) begin
                    if (exp_b.size() == 0) fail("b_unexpected");
                    else begin
                        eb = exp_b.pop_front();
                        chk("b_resp", 64'(o_axi_bresp), 64'(eb.resp));
                        chk("b_id", 64'(o_axi_bid), 64'(eb.id));
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_aw(input logic id, input logic [27:0] a, input logic [7:0] len, input logic [1:0] b);
        int t = 0;
        @(posedge i_clk); #1;
        i_axi_awvalid = 1'b1; i_axi_awid = id; i_axi_awaddr = a; i_axi_awlen = len; i_axi_awburst = b;
        do begin @(negedge i_clk); t++; end while (!o_axi_awready && t < 2000);
        if (!o_axi_awready) fail("aw_handshake_timeout");
        @(posedge i_clk); #1;
        i_axi_awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic id, input logic [27:0] a, input logic [7:0] len, input logic [1:0] b);
        int t = 0;
        @(posedge i_clk); #1;
        i_axi_arvalid = 1'b1; i_axi_arid = id; i_axi_araddr = a; i_axi_arlen = len; i_axi_arburst = b;
        do begin @(negedge i_clk); t++; end while (!o_axi_arready && t < 2000);
        if (!o_axi_arready) fail("ar_handshake_timeout");
        @(posedge i_clk); #1;
        i_axi_arvalid = 1'b0;
    endtask

    task automatic do_w(input logic [7:0] len);
        int t;
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom % 3 == 0) begin @(posedge i_clk); #1; end
            i_axi_wvalid = 1'b1; i_axi_wdata = wd[i]; i_axi_wstrb = ws[i]; i_axi_wlast = (i == int'(len));
            t = 0;
            do begin @(negedge i_clk); t++; end while (!o_axi_wready && t < 2000);
            if (!o_axi_wready) fail("w_handshake_timeout");
            @(posedge i_clk); #1;
            i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0;
        end
    endtask

    task automatic gen_w();
        for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic write_burst(input logic id, input logic [27:0] a, input logic [7:0] len, input logic [1:0] b);
        model_write(id, a, len, b);
        do_aw(id, a, len, b);
        do_w(len);
    endtask

    task automatic read_burst(input logic id, input logic [27:0] a, input logic [7:0] len, input logic [1:0] b);
        model_read(id, a, len, b);
        do_ar(id, a, len, b);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_wb.size() != 0 || exp_r.size() != 0 || exp_b.size() != 0) && t < 4000) begin
            @(negedge i_clk); t++;
        end
        if (t >= 4000) begin
            fail("burst_completion_timeout");
            exp_wb.delete(); exp_r.delete(); exp_b.delete();
        end
        repeat (2) @(posedge i_clk);
    endtask

    // simultaneous AW and AR; model decides which burst the bridge serves first
    task automatic tie(input logic [27:0] wa, input logic [27:0] ra);
        gen_w();
        if (!last_rd) begin
            model_read(1'b1, ra, 8'd1, 2'b01);
            model_write(1'b0, wa, 8'd1, 2'b01);
        end else begin
            model_write(1'b0, wa, 8'd1, 2'b01);
            model_read(1'b1, ra, 8'd1, 2'b01);
        end
        fork
            do_ar(1'b1, ra, 8'd1, 2'b01);
            begin do_aw(1'b0, wa, 8'd1, 2'b01); do_w(8'd1); end
        join
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        logic [7:0] len;
        logic [1:0] b;
        i_rst = 1'b1;
        i_axi_awvalid = 0; i_axi_awid = 0; i_axi_awaddr = 0; i_axi_awlen = 0; i_axi_awburst = 0;
        i_axi_arvalid = 0; i_axi_arid = 0; i_axi_araddr = 0; i_axi_arlen = 0; i_axi_arburst = 0;
        i_axi_wvalid = 0; i_axi_wdata = 0; i_axi_wstrb = 0; i_axi_wlast = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_cyc", 64'(o_wb_cyc), 64'(0));
        chk("rst_stb", 64'(o_wb_stb), 64'(0));
        chk("rst_awready", 64'(o_axi_awready), 64'(0));
        chk("rst_arready", 64'(o_axi_arready), 64'(0));
        chk("rst_wready", 64'(o_axi_wready), 64'(0));
        chk("rst_bvalid", 64'(o_axi_bvalid), 64'(0));
        chk("rst_rvalid", 64'(o_axi_rvalid), 64'(0));
        chk("rst_bresp", 64'(o_axi_bresp), 64'(0));
        chk("rst_rresp", 64'(o_axi_rresp), 64'(0));
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);

        // ties after reset: read first, then alternating
        tie(28'h0000400, 28'h0000800);
        tie(28'h0000410, 28'h0000810);
        tie(28'h0000420, 28'h0000820);

        // single-beat write
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        write_burst(1'b1, 28'h0000010, 8'd0, 2'b01);
        wait_done();

        // 4-beat INCR read
        read_burst(1'b0, 28'h0000100, 8'd3, 2'b01);
        wait_done();

        // read with R held off
        r_hold = 5;
        read_burst(1'b1, 28'h0000200, 8'd2, 2'b01);
        wait_done();

        // WB error on beat 2 of a write, and of a read
        err_mode = 1'b1;
        gen_w();
        write_burst(1'b0, 28'h0000300, 8'd3, 2'b01);
        wait_done();
        read_burst(1'b1, 28'h0000300, 8'd3, 2'b01);
        wait_done();
        err_mode = 1'b0;

        // WRAP read/write, FIXED read, INCR across the top of the word space
        read_burst(1'b0, 28'h0000108, 8'd3, 2'b10);
        wait_done();
        gen_w();
        write_burst(1'b1, 28'h0000A14, 8'd7, 2'b10);
        wait_done();
        read_burst(1'b0, 28'h0000600, 8'd2, 2'b00);
        wait_done();
        gen_w();
        write_burst(1'b0, 28'hFFFFFF8, 8'd3, 2'b01);
        wait_done();

        // randomized bursts
        for (int n = 0; n < 40; n++) begin
            b = 2'($urandom_range(0, 2));
            if (b == 2'b10) len = 8'((2 << $urandom_range(0, 3)) - 1);
            else            len = 8'($urandom_range(0, 7));
            err_mode = ($urandom % 4) == 0;
            gen_w();
            if ($urandom % 2) write_burst(1'($urandom), 28'($urandom), len, b);
            else              read_burst(1'($urandom), 28'($urandom), len, b);
            wait_done();
        end
        err_mode = 1'b0;

        // reset while a write strobe is stalled
        force_stall = 1'b1;
        repeat (2) @(posedge i_clk);
        gen_w();
        do_aw(1'b1, 28'h0000040, 8'd0, 2'b01);
        do_w(8'd0);
        t = 0;
        while (!o_wb_stb && t < 50) begin @(negedge i_clk); t++; end
        chk("rst_mid_stb_seen", 64'(o_wb_stb), 64'(1));
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("rst_mid_cyc", 64'(o_wb_cyc), 64'(0));
        chk("rst_mid_stb", 64'(o_wb_stb), 64'(0));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        last_rd = 1'b0;
        force_stall = 1'b0;
        repeat (10) begin
            @(negedge i_clk);
            chk("rst_mid_bvalid", 64'(o_axi_bvalid), 64'(0));
            chk("rst_mid_rvalid", 64'(o_axi_rvalid), 64'(0));
        end

        // recovery after reset
        gen_w();
        write_burst(1'b0, 28'h0000080, 8'd1, 2'b01);
        wait_done();
        tie(28'h0000900, 28'h0000A00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
